// File: rtl/pixel_combinator.sv
// Pops the lowest-index queue whose head matches the scan coordinate and
// registers it as a pixel stream. Optional stall timeout: PIXEL_COMBINATOR_TIMEOUT_EN.
module pixel_combinator #(
  parameter int DATA_WIDTH     = 32,
  parameter int RBG_SIZE       = 24,
  parameter int NUM_QUEUES     = 4,
  parameter int IMAGE_W        = 640,
  parameter int IMAGE_H        = 480,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           enable_i,
  input  logic [NUM_QUEUES-1:0]          match_i,
  input  logic [NUM_QUEUES*RBG_SIZE-1:0] colour_i,
  output logic [DATA_WIDTH-1:0]          xpixel_check,
  output logic [DATA_WIDTH-1:0]          ypixel_check,
  output logic [NUM_QUEUES-1:0]          pop_o,
  output logic [RBG_SIZE-1:0]            pixel_data,
  output logic                           pixel_valid,
  input  logic                           pixel_ready,
  output logic                           sop,
  output logic                           eop,
  output logic                           frame_done,
  output logic                           dup_err
`ifdef PIXEL_COMBINATOR_TIMEOUT_EN
  ,
  output logic                           timeout_err
`endif
);

  typedef enum logic {SCAN, HOLD} state_t;

  localparam logic [DATA_WIDTH-1:0] X_LAST = DATA_WIDTH'(IMAGE_W - 1);
  localparam logic [DATA_WIDTH-1:0] Y_LAST = DATA_WIDTH'(IMAGE_H - 1);

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   x_q, x_d, y_q, y_d;
  logic [RBG_SIZE-1:0]     data_q, data_d;
  logic                    valid_q, valid_d;
  logic                    sop_q, sop_d, eop_q, eop_d;
  logic                    frame_done_q, frame_done_d;
  logic                    dup_err_q, dup_err_d;

  logic [NUM_QUEUES-1:0]   pop_sel;
  logic [RBG_SIZE-1:0]     sel_colour;
  logic                    found, multi;
  logic                    slot_free, pop_go, fire, load;
  logic                    at_first, at_last;

  // Priority pick: first set bit wins, any further set bit flags a duplicate.
  always_comb begin
    pop_sel    = '0;
    sel_colour = '0;
    found      = 1'b0;
    multi      = 1'b0;
    for (int q = 0; q < NUM_QUEUES; q++) begin
      if (match_i[q]) begin
        if (found) begin
          multi = 1'b1;
        end else begin
          found      = 1'b1;
          pop_sel[q] = 1'b1;
          sel_colour = colour_i[q*RBG_SIZE +: RBG_SIZE];
        end
      end
    end
  end

  assign slot_free = !valid_q || pixel_ready;
  assign pop_go    = (state_q == SCAN) && enable_i && found && slot_free;
  assign pop_o     = pop_go ? pop_sel : '0;
  assign load      = pop_go || fire;
  assign at_first  = (x_q == '0) && (y_q == '0);
  assign at_last   = (x_q == X_LAST) && (y_q == Y_LAST);

`ifdef PIXEL_COMBINATOR_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          timeout_err_q, timeout_err_d;
  logic          stall_tick;

  assign stall_tick = (state_q == SCAN) && enable_i && !found && slot_free;
  assign fire       = stall_tick && (tcnt_q == TW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    tcnt_d        = tcnt_q;
    timeout_err_d = timeout_err_q;
    if (pop_go || fire) begin
      tcnt_d = '0;
    end else if (stall_tick) begin
      tcnt_d = tcnt_q + TW'(1);
    end
    if (fire) timeout_err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tcnt_q        <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      tcnt_q        <= tcnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign timeout_err = timeout_err_q;
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = 32'(TIMEOUT_CYCLES);
  assign fire           = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    data_d       = data_q;
    valid_d      = valid_q;
    sop_d        = sop_q;
    eop_d        = eop_q;
    frame_done_d = 1'b0;
    dup_err_d    = dup_err_q;

    case (state_q)
      SCAN:    if (valid_q && !pixel_ready) state_d = HOLD;
      HOLD:    if (pixel_ready) state_d = SCAN;
      default: state_d = SCAN;
    endcase

    // A timeout load behaves like a pop of a black pixel.
    if (load) begin
      data_d       = pop_go ? sel_colour : '0;
      valid_d      = 1'b1;
      sop_d        = at_first;
      eop_d        = at_last;
      frame_done_d = at_last;
      if (x_q == X_LAST) begin
        x_d = '0;
        y_d = (y_q == Y_LAST) ? '0 : y_q + DATA_WIDTH'(1);
      end else begin
        x_d = x_q + DATA_WIDTH'(1);
      end
    end else if (valid_q && pixel_ready) begin
      valid_d = 1'b0;
      sop_d   = 1'b0;
      eop_d   = 1'b0;
    end

    if (pop_go && multi) dup_err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= SCAN;
      x_q          <= '0;
      y_q          <= '0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      sop_q        <= 1'b0;
      eop_q        <= 1'b0;
      frame_done_q <= 1'b0;
      dup_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      sop_q        <= sop_d;
      eop_q        <= eop_d;
      frame_done_q <= frame_done_d;
      dup_err_q    <= dup_err_d;
    end
  end

  assign xpixel_check = x_q;
  assign ypixel_check = y_q;
  assign pixel_data   = data_q;
  assign pixel_valid  = valid_q;
  assign sop          = sop_q;
  assign eop          = eop_q;
  assign frame_done   = frame_done_q;
  assign dup_err      = dup_err_q;

endmodule
